// File: rtl/return_stack.sv
// Return-address LIFO for call/return: push writes PC+4, pop hands the top back to fetch.
// State updates on the clk edge; pop_data/pop_valid one cycle later; refused ops set sticky flags.
module return_stack #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] top_data,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic [ADDR_W:0]       count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W:0]       cnt_q;
   logic [ADDR_W-1:0]     wr_idx;
   logic [ADDR_W-1:0]     top_idx;
   logic                  push_ok;
   logic                  replace;
   logic                  pop_ok;
   logic                  ovf_set;
   logic                  unf_set;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_idx;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (ADDR_W+1)'(DEPTH));
   assign count   = cnt_q;
   assign wr_idx  = cnt_q[ADDR_W-1:0];
   assign top_idx = cnt_q[ADDR_W-1:0] - 1'b1;

   // Push+pop on a non-empty stack overwrites the top in place; on an empty
   // stack the push still lands while the pop is refused.
   assign replace = push && pop && !empty;
   assign push_ok = push && (pop ? empty : !full);
   assign pop_ok  = pop && !empty;
   assign ovf_set = push && !pop && full;
   assign unf_set = pop && empty;

   assign mem_we  = push_ok || replace;
   assign mem_idx = replace ? top_idx : wr_idx;

   assign top_data = empty ? '0 : mem[top_idx];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         pop_data  <= '0;
         pop_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pop_valid <= pop_ok;
         if (pop_ok) begin
            pop_data <= mem[top_idx];
         end
         if (push_ok) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (pop_ok && !push) begin
            cnt_q <= cnt_q - 1'b1;
         end
         // A fresh error in the clearing cycle takes priority over the clear.
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (unf_set) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: one task per scenario, inline checks, one summary line.
module tb_return_stack;

   logic        clk;
   logic        rst;
   logic        push;
   logic        pop;
   logic [31:0] push_data;
   logic        err_clr;
   logic [31:0] top_data;
   logic [31:0] pop_data;
   logic        pop_valid;
   logic [4:0]  count;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        underflow;

   int checks;
   int errors;

   return_stack #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .err_clr   (err_clr),
      .top_data  (top_data),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      #1;
      checks++; if (count !== 5'd0)      begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++; if (pop_valid !== 1'b0)  begin errors++; $display("FAIL reset_pop_valid got %b exp 0", pop_valid); end
      checks++; if (pop_data !== 32'h0)  begin errors++; $display("FAIL reset_pop_data got %h exp 0", pop_data); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
      checks++; if (top_data !== 32'h0)  begin errors++; $display("FAIL reset_top got %h exp 0", top_data); end
      #1 rst = 1'b0;
   endtask

   task automatic test_push();
      push = 1'b1; push_data = 32'h0040_0004; tick();
      push_data = 32'h0040_0010; tick();
      idle();
      checks++; if (count !== 5'd2)            begin errors++; $display("FAIL push_count got %0d exp 2", count); end
      checks++; if (top_data !== 32'h0040_0010) begin errors++; $display("FAIL push_top got %h exp 00400010", top_data); end
      checks++; if (empty !== 1'b0)            begin errors++; $display("FAIL push_empty got %b exp 0", empty); end
   endtask

   task automatic test_pop();
      pop = 1'b1; tick();
      checks++; if (pop_data !== 32'h0040_0010) begin errors++; $display("FAIL pop1_data got %h exp 00400010", pop_data); end
      checks++; if (pop_valid !== 1'b1)         begin errors++; $display("FAIL pop1_valid got %b exp 1", pop_valid); end
      checks++; if (top_data !== 32'h0040_0004) begin errors++; $display("FAIL pop1_top got %h exp 00400004", top_data); end
      tick();
      checks++; if (pop_data !== 32'h0040_0004) begin errors++; $display("FAIL pop2_data got %h exp 00400004", pop_data); end
      checks++; if (pop_valid !== 1'b1)         begin errors++; $display("FAIL pop2_valid got %b exp 1", pop_valid); end
      checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL pop2_count got %0d/%b exp 0/1", count, empty); end
      checks++; if (top_data !== 32'h0)         begin errors++; $display("FAIL pop2_top got %h exp 0", top_data); end
      idle(); tick();
      checks++; if (pop_valid !== 1'b0)         begin errors++; $display("FAIL pop_idle_valid got %b exp 0", pop_valid); end
      checks++; if (underflow !== 1'b0)         begin errors++; $display("FAIL pop_no_underflow got %b exp 0", underflow); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) begin
         push = 1'b1; push_data = 32'h100 + 32'(i); tick();
      end
      idle();
      checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL fill_full got %b/%0d exp 1/16", full, count); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL fill_no_overflow got %b exp 0", overflow); end
      push = 1'b1; push_data = 32'h0000_DEAD; tick();
      idle();
      checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d/%b exp 16/1", count, full); end
      checks++; if (top_data !== 32'h10F) begin errors++; $display("FAIL ovf_top got %h exp 0000010f", top_data); end
   endtask

   task automatic test_replace();
      push = 1'b1; pop = 1'b1; push_data = 32'h0000_BEEF; tick();
      idle();
      checks++; if (pop_data !== 32'h10F || pop_valid !== 1'b1) begin errors++; $display("FAIL repl_pop got %h/%b exp 0000010f/1", pop_data, pop_valid); end
      checks++; if (top_data !== 32'hBEEF) begin errors++; $display("FAIL repl_top got %h exp 0000beef", top_data); end
      checks++; if (count !== 5'd16)       begin errors++; $display("FAIL repl_count got %0d exp 16", count); end
      checks++; if (overflow !== 1'b1)     begin errors++; $display("FAIL repl_overflow got %b exp 1", overflow); end
      err_clr = 1'b1; tick(); idle();
      checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
      pop = 1'b1; tick();
      checks++; if (pop_data !== 32'hBEEF) begin errors++; $display("FAIL drain_first got %h exp 0000beef", pop_data); end
      tick();
      checks++; if (pop_data !== 32'h10E)  begin errors++; $display("FAIL drain_second got %h exp 0000010e", pop_data); end
      for (int i = 0; i < 14; i++) tick();
      idle();
      checks++; if (pop_data !== 32'h100)  begin errors++; $display("FAIL drain_last got %h exp 00000100", pop_data); end
      checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL drain_empty got %b/%b exp 1/0", empty, underflow); end
   endtask

   task automatic test_underflow();
      pop = 1'b1; tick(); idle();
      checks++; if (underflow !== 1'b1)   begin errors++; $display("FAIL unf_flag got %b exp 1", underflow); end
      checks++; if (pop_valid !== 1'b0)   begin errors++; $display("FAIL unf_valid got %b exp 0", pop_valid); end
      checks++; if (pop_data !== 32'h100) begin errors++; $display("FAIL unf_hold got %h exp 00000100", pop_data); end
      err_clr = 1'b1; pop = 1'b1; tick(); idle();
      checks++; if (underflow !== 1'b1)   begin errors++; $display("FAIL unf_set_wins got %b exp 1", underflow); end
      err_clr = 1'b1; tick(); idle();
      checks++; if (underflow !== 1'b0)   begin errors++; $display("FAIL unf_clear got %b exp 0", underflow); end
      push = 1'b1; pop = 1'b1; push_data = 32'h55; tick(); idle();
      checks++; if (count !== 5'd1 || top_data !== 32'h55) begin errors++; $display("FAIL pp_empty got %0d/%h exp 1/00000055", count, top_data); end
      checks++; if (underflow !== 1'b1 || pop_valid !== 1'b0) begin errors++; $display("FAIL pp_empty_flags got %b/%b exp 1/0", underflow, pop_valid); end
      pop = 1'b1; err_clr = 1'b1; tick(); idle();
      checks++; if (pop_data !== 32'h55 || empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL pp_drain got %h/%b/%b exp 00000055/1/0", pop_data, empty, underflow); end
   endtask

   task automatic test_async_reset();
      push = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         push_data = 32'(i); tick();
      end
      push = 1'b0; pop = 1'b1; tick(); idle();
      checks++; if (pop_valid !== 1'b1 || count !== 5'd2) begin errors++; $display("FAIL pre_rst got %b/%0d exp 1/2", pop_valid, count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL arst_count got %0d/%b exp 0/1", count, empty); end
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", pop_valid); end
      checks++; if (top_data !== 32'h0 || pop_data !== 32'h0) begin errors++; $display("FAIL arst_data got %h/%h exp 0/0", top_data, pop_data); end
      #1 rst = 1'b0;
      tick();
      checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL post_rst got %0d/%b exp 0/1", count, empty); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_push();
      test_pop();
      test_overflow();
      test_replace();
      test_underflow();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
